ascensor_sched: RTL
===================

ASCENSOR_SCHED -- requirements
Module: ascensor_sched

Interface
REQ-001 SHALL have parameter DOOR_HOLD, default 100, cycles doors stay open before closing.
REQ-002 SHALL have parameter MOVE_TIMEOUT, default 1000, max cycles between cambio_piso pulses while moving.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port botones  in  10  floor call buttons, bit i = floor i, level, may be held.
REQ-006 SHALL have port boton_puertas  in  2  [0] open request, [1] close request.
REQ-007 SHALL have port estado_puertas  in  2  door status: 00 closed, 11 fully open, 01/10 in motion.
REQ-008 SHALL have port cambio_piso  in  1  one-cycle pulse per floor boundary reached.
REQ-009 SHALL have port sensor_puertas  in  1  door obstruction, high = blocked.
REQ-010 SHALL have port luces  out  10  pending-request lamps, registered.
REQ-011 SHALL have port display  out  4  current floor, binary 0..9, registered.
REQ-012 SHALL have port aviso  out  4  status: 0 idle, 1 up, 2 down, 3 doors, 4 obstruction, F fault.
REQ-013 SHALL have port puertas  out  2  door command: 00 hold, 01 open, 10 close.
REQ-014 SHALL have port motor  out  2  motor command: 00 stop, 01 up, 10 down.

Function
REQ-015 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, OPENING, OPEN_HOLD, CLOSING, FAULT.
REQ-016 SHALL set luces[i] the cycle after botones[i] is high; luces[i] clears only when doors reach 11 at floor i.
REQ-017 SHALL, in IDLE: luces[floor] set -> OPENING; else continue last direction if a request lies that way; else reverse; else stay IDLE.
REQ-018 SHALL, in MOVE_UP/MOVE_DOWN, drive motor 01/10 and on cambio_piso increment/decrement floor, go to ARRIVE if luces[new floor] set.
REQ-019 SHALL go to FAULT on cambio_piso in MOVE_UP at floor 9 or MOVE_DOWN at floor 0 (no wrap).
REQ-020 SHALL go to FAULT if estado_puertas != 00 in any MOVE state; motor is nonzero only in MOVE states.
REQ-021 SHALL hold motor 00 for exactly one cycle in ARRIVE, then enter OPENING.
REQ-022 SHALL drive puertas 01 in OPENING until estado_puertas = 11, then clear luces[floor], load timer with DOOR_HOLD, enter OPEN_HOLD.
REQ-023 SHALL, in OPEN_HOLD, drive puertas 00 and decrement timer; boton_puertas[0], sensor_puertas, or botones[floor] reload DOOR_HOLD; boton_puertas[1] forces timer 0; at 0 enter CLOSING.
REQ-024 SHALL give open priority when boton_puertas = 11 in the same cycle.
REQ-025 SHALL, in CLOSING, drive puertas 10; sensor_puertas or boton_puertas[0] -> OPENING; estado_puertas = 00 -> IDLE.
REQ-026 SHALL set aviso 4 whenever sensor_puertas is high in OPENING/OPEN_HOLD/CLOSING, else per state.
REQ-027 SHALL, in FAULT, drive motor 00, puertas 00, aviso F; FAULT exits only by reset.

Reset
REQ-028 SHALL on reset low immediately set motor 00, puertas 00, aviso 0, luces 0, display 0, state IDLE, direction up, timers 0, including mid-move.
REQ-029 SHALL ignore botones during reset; first capture occurs the first clock edge after release.

Configuration
REQ-030 SHALL, with ASCENSOR_TIMEOUT_EN defined, count cycles in MOVE states, clear on cambio_piso, and enter FAULT when count reaches MOVE_TIMEOUT.
REQ-031 SHALL, without ASCENSOR_TIMEOUT_EN, omit the move counter; interlock and end-of-shaft faults remain.

Verification
REQ-032 SHALL cover: idle at 0, botones[3] pulse -> motor 01, three cambio_piso -> display 3, motor 00, puertas 01, luces[3] clears at estado 11.
REQ-033 SHALL cover: requests 5 and 2 while moving up from 0 -> serves 5 first, then motor 10 to 2.
REQ-034 SHALL cover: sensor_puertas high during CLOSING -> puertas 01 next cycle, aviso 4.
REQ-035 SHALL cover: boton_puertas = 11 in OPEN_HOLD -> timer reloaded, doors stay open DOOR_HOLD more cycles.
REQ-036 SHALL cover: with ASCENSOR_TIMEOUT_EN, no cambio_piso for MOVE_TIMEOUT cycles -> motor 00, aviso F until reset.
REQ-037 SHALL cover: reset asserted mid MOVE_UP -> motor 00 without waiting for clk, display 0 after release.

Source files
------------

// File: rtl/ascensor_sched.sv
// ascensor_sched: ten-floor elevator scheduler; define ASCENSOR_TIMEOUT_EN to add a move watchdog
module ascensor_sched #(
    parameter int DOOR_HOLD    = 100,
    parameter int MOVE_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] botones,
    input  logic [1:0] boton_puertas,
    input  logic [1:0] estado_puertas,
    input  logic       cambio_piso,
    input  logic       sensor_puertas,
    output logic [9:0] luces,
    output logic [3:0] display,
    output logic [3:0] aviso,
    output logic [1:0] puertas,
    output logic [1:0] motor
);
    localparam int TW = $clog2(DOOR_HOLD + 1);
    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, OPENING, OPEN_HOLD, CLOSING, FAULT} state_t;
    state_t        state_q, state_d;
    logic [3:0]    floor_q, floor_d, nf;
    logic          dir_up_q, dir_up_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    luces_d;
    logic          up_req, down_req, moving, door_st, wd_fault;
    logic [1:0]    motor_d, puertas_d;
    logic [3:0]    aviso_d;

    assign moving = state_q == MOVE_UP || state_q == MOVE_DOWN;
    assign nf     = state_q == MOVE_UP ? floor_q + 4'd1 : floor_q - 4'd1;

`ifdef ASCENSOR_TIMEOUT_EN
    localparam int CW = $clog2(MOVE_TIMEOUT + 1);
    logic [CW-1:0] mv_cnt_q, mv_cnt_d;
    assign mv_cnt_d = (moving && !cambio_piso) ? mv_cnt_q + 1'b1 : '0;
    assign wd_fault = moving && !cambio_piso && mv_cnt_d == CW'(MOVE_TIMEOUT);
    // Cycles spent moving since the last floor boundary; reaching the limit means a stuck car
    always_ff @(posedge clk or negedge reset)
        if (!reset) mv_cnt_q <= '0;
        else        mv_cnt_q <= mv_cnt_d;
`else
    assign wd_fault = 1'b0;
`endif

    // Pending lamps strictly above and strictly below the current floor
    always_comb begin
        up_req   = 1'b0;
        down_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            up_req   = up_req   | (luces[i] & (4'(i) > floor_q));
            down_req = down_req | (luces[i] & (4'(i) < floor_q));
        end
    end

    // Next state, floor, direction, door timer and request lamps
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;
        luces_d  = luces | botones;
        case (state_q)
            IDLE:
                if (luces[floor_q]) state_d = OPENING;
                else if (up_req && (dir_up_q || !down_req)) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (down_req) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            MOVE_UP, MOVE_DOWN:
                if (estado_puertas != 2'b00 || wd_fault) state_d = FAULT;
                else if (cambio_piso) begin
                    if ((state_q == MOVE_UP && floor_q == 4'd9) || (state_q == MOVE_DOWN && floor_q == 4'd0))
                        state_d = FAULT;
                    else begin
                        floor_d = nf;
                        if (luces[nf]) state_d = ARRIVE;
                    end
                end
            ARRIVE: state_d = OPENING;
            OPENING:
                if (estado_puertas == 2'b11) begin
                    luces_d[floor_q] = 1'b0;
                    timer_d          = TW'(DOOR_HOLD);
                    state_d          = OPEN_HOLD;
                end
            // Open requests win over a simultaneous close request
            OPEN_HOLD:
                if (boton_puertas[0] || sensor_puertas || botones[floor_q]) timer_d = TW'(DOOR_HOLD);
                else if (boton_puertas[1] || timer_q <= TW'(1)) begin
                    timer_d = '0;
                    state_d = CLOSING;
                end else timer_d = timer_q - 1'b1;
            CLOSING:
                if (sensor_puertas || boton_puertas[0]) state_d = OPENING;
                else if (estado_puertas == 2'b00) state_d = IDLE;
            default: state_d = FAULT;
        endcase
    end

    assign door_st   = state_d inside {OPENING, OPEN_HOLD, CLOSING};
    assign motor_d   = state_d == MOVE_UP ? 2'b01 : state_d == MOVE_DOWN ? 2'b10 : 2'b00;
    assign puertas_d = state_d == OPENING ? 2'b01 : state_d == CLOSING ? 2'b10 : 2'b00;
    assign aviso_d   = state_d == FAULT ? 4'hF : (door_st && sensor_puertas) ? 4'd4 :
                       state_d == MOVE_UP ? 4'd1 : state_d == MOVE_DOWN ? 4'd2 :
                       state_d == IDLE ? 4'd0 : 4'd3;

    // State register; outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_up_q <= 1'b1;
            timer_q  <= '0;
            luces    <= '0;
            motor    <= 2'b00;
            puertas  <= 2'b00;
            aviso    <= 4'd0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_up_q <= dir_up_d;
            timer_q  <= timer_d;
            luces    <= luces_d;
            motor    <= motor_d;
            puertas  <= puertas_d;
            aviso    <= aviso_d;
        end

    assign display = floor_q;
endmodule
